// File: rtl/prime_fibo_checker.sv
// Receive-side monitor for the 6-bit prime/Fibonacci up/down counter: identifies
// the running sequence, locks onto it, and flags every broken transition.
module prime_fibo_checker #(
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned ERRW     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [5:0]      din,
    output logic            locked,
    output logic            PorF,
    output logic            UorD,
    output logic [3:0]      index,
    output logic            err,
    output logic [ERRW-1:0] err_count
);

    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] ACQ   = 2'd1;
    localparam logic [1:0] TRACK = 2'd2;

    localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);

    function automatic logic [5:0] tbl(input logic fib, input logic [3:0] i);
        logic [5:0] v;
        v = '0;
        if (fib) begin
            case (i)
                4'd0:    v = 6'd0;
                4'd1:    v = 6'd1;
                4'd2:    v = 6'd1;
                4'd3:    v = 6'd2;
                4'd4:    v = 6'd3;
                4'd5:    v = 6'd5;
                4'd6:    v = 6'd8;
                4'd7:    v = 6'd13;
                4'd8:    v = 6'd21;
                4'd9:    v = 6'd34;
                4'd10:   v = 6'd55;
                default: v = 6'd0;
            endcase
        end else begin
            case (i)
                4'd0:    v = 6'd2;
                4'd1:    v = 6'd3;
                4'd2:    v = 6'd5;
                4'd3:    v = 6'd7;
                4'd4:    v = 6'd11;
                4'd5:    v = 6'd13;
                4'd6:    v = 6'd17;
                4'd7:    v = 6'd19;
                4'd8:    v = 6'd23;
                4'd9:    v = 6'd29;
                4'd10:   v = 6'd31;
                default: v = 6'd0;
            endcase
        end
        return v;
    endfunction

    // {hit, index} of the first table position holding v (Fibonacci 1 maps to 1a)
    function automatic logic [4:0] lookup(input logic fib, input logic [5:0] v);
        logic [4:0] r;
        r = '0;
        for (int unsigned k = 0; k < 11; k++) begin
            if (!r[4] && tbl(fib, 4'(k)) == v) r = {1'b1, 4'(k)};
        end
        return r;
    endfunction

    function automatic logic [3:0] nxt(input logic dn, input logic [3:0] i);
        if (dn) return (i == 4'd0)  ? 4'd10 : i - 4'd1;
        else    return (i == 4'd10) ? 4'd0  : i + 4'd1;
    endfunction

    // A first-sample 1 sits at 1a; when amb is set, 1b is tried as well.
    function automatic logic [4:0] advance(input logic fib, input logic dn, input logic amb1,
                                           input logic [3:0] idx, input logic [5:0] v);
        logic [3:0] n1;
        logic [3:0] n2;
        n1 = nxt(dn, idx);
        n2 = nxt(dn, 4'd2);
        if (tbl(fib, n1) == v)                 return {1'b1, n1};
        if (amb1 && fib && tbl(fib, n2) == v)  return {1'b1, n2};
        return {1'b0, n1};
    endfunction

    logic [1:0]      state_q, state_d;
    logic [3:0]      mask_q, mask_d;      // {PU, PD, FU, FD}
    logic [3:0]      mcnt_q, mcnt_d;
    logic [5:0]      prev_q, prev_d;
    logic [3:0]      cidx_q [4];
    logic [3:0]      cidx_d [4];
    logic            locked_q, locked_d;
    logic            porf_q, porf_d;
    logic            uord_q, uord_d;
    logic [3:0]      index_q, index_d;
    logic            err_q, err_d;
    logic [ERRW-1:0] errc_q, errc_d;

    logic [4:0] plk, flk;
    logic [3:0] ld_mask;
    logic       amb;
    logic [4:0] adv [4];
    logic [3:0] hit;
    logic [3:0] sel_idx;
    logic [3:0] mcnt_inc;
    logic       restart;

    always_comb begin
        plk     = lookup(1'b0, din);
        flk     = lookup(1'b1, din);
        ld_mask = {plk[4], plk[4], flk[4], flk[4]};
        amb     = (state_q == ACQ) && (mcnt_q == '0) && (prev_q == 6'd1);
        hit     = '0;
        sel_idx = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            adv[c] = advance(!c[1], !c[0], amb, cidx_q[c], din);
            hit[c] = mask_q[c] & adv[c][4];
            if (hit[c]) sel_idx = adv[c][3:0];
        end
        mcnt_inc = (mcnt_q >= LOCK_N) ? mcnt_q : mcnt_q + 4'd1;

        state_d  = state_q;
        mask_d   = mask_q;
        mcnt_d   = mcnt_q;
        prev_d   = prev_q;
        cidx_d   = cidx_q;
        locked_d = locked_q;
        porf_d   = porf_q;
        uord_d   = uord_q;
        index_d  = index_q;
        err_d    = 1'b0;
        errc_d   = errc_q;
        restart  = 1'b0;

        if (enable) begin
            prev_d = din;
            case (state_q)
                HUNT: restart = 1'b1;
                ACQ: begin
                    if (|hit) begin
                        mask_d = hit;
                        mcnt_d = mcnt_inc;
                        for (int unsigned c = 0; c < 4; c++) cidx_d[c] = adv[c][3:0];
                        if ($onehot(hit) && mcnt_inc == LOCK_N) begin
                            state_d  = TRACK;
                            locked_d = 1'b1;
                            porf_d   = hit[1] | hit[0];
                            uord_d   = hit[2] | hit[0];
                            index_d  = sel_idx;
                        end
                    end else begin
                        restart = 1'b1;
                    end
                end
                TRACK: begin
                    if (|hit) begin
                        for (int unsigned c = 0; c < 4; c++) cidx_d[c] = adv[c][3:0];
                        index_d = sel_idx;
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        if (errc_q != '1) errc_d = errc_q + ERRW'(1);
                        restart  = 1'b1;
                    end
                end
                default: restart = 1'b1;
            endcase

            // Every failed path re-enters acquisition using this sample as the first one
            if (restart) begin
                mask_d    = ld_mask;
                mcnt_d    = '0;
                state_d   = (|ld_mask) ? ACQ : HUNT;
                cidx_d[3] = plk[3:0];
                cidx_d[2] = plk[3:0];
                cidx_d[1] = flk[3:0];
                cidx_d[0] = flk[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            mask_q   <= '0;
            mcnt_q   <= '0;
            prev_q   <= '0;
            cidx_q   <= '{default: '0};
            locked_q <= 1'b0;
            porf_q   <= 1'b0;
            uord_q   <= 1'b0;
            index_q  <= '0;
            err_q    <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            mcnt_q   <= mcnt_d;
            prev_q   <= prev_d;
            cidx_q   <= cidx_d;
            locked_q <= locked_d;
            porf_q   <= porf_d;
            uord_q   <= uord_d;
            index_q  <= index_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
        end
    end

    assign locked    = locked_q;
    assign PorF      = porf_q;
    assign UorD      = uord_q;
    assign index     = index_q;
    assign err       = err_q;
    assign err_count = errc_q;

endmodule
